// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: sync, deglitch, 11-bit frame decode,
// byte FIFO, sticky errors and level irq.
// Ports:
//   clk_i, rst_i     core clock, synchronous active-high reset
//   en_i             receiver enable
//   ps2_clk_i/dat_i  raw PS/2 lines
//   rd_en_i          pop FIFO head
//   irq_thresh_i     FIFO level irq threshold (0 = off)
//   clr_err_i        clear sticky errors
//   dat_o            FIFO head (fall-through)
//   empty_o, full_o, count_o   FIFO status
//   par_err_o, frm_err_o, ovf_o  sticky errors
//   irq_o            registered interrupt
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH  = 8,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 5000,
  parameter int CNT_W       = $clog2(FIFO_DEPTH+1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             ps2_clk_i,
  input  logic             ps2_dat_i,
  input  logic             rd_en_i,
  input  logic [CNT_W-1:0] irq_thresh_i,
  input  logic             clr_err_i,
  output logic [7:0]       dat_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CNT_W-1:0] count_o,
  output logic             par_err_o,
  output logic             frm_err_o,
  output logic             ovf_o,
  output logic             irq_o
);

  localparam int FW = $clog2(FILTER_LEN+1);
  localparam int TW = $clog2(TIMEOUT_CYC+1);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE, S_DATA, S_PAR, S_STOP
  } state_t;

  logic [1:0]    r_clk_s, r_dat_s;
  logic          r_clk_f, r_dat_f, r_clk_fd;
  logic [FW-1:0] r_clk_fc, r_dat_fc;
  logic          w_fall;

  // Filtered value only moves after FILTER_LEN
  // consecutive disagreeing samples.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_clk_s  <= 2'b11;
      r_dat_s  <= 2'b11;
      r_clk_f  <= 1'b1;
      r_dat_f  <= 1'b1;
      r_clk_fd <= 1'b1;
      r_clk_fc <= '0;
      r_dat_fc <= '0;
    end else begin
      r_clk_s  <= {r_clk_s[0], ps2_clk_i};
      r_dat_s  <= {r_dat_s[0], ps2_dat_i};
      r_clk_fd <= r_clk_f;
      if (r_clk_s[1] == r_clk_f) begin
        r_clk_fc <= '0;
      end else if (r_clk_fc == FW'(FILTER_LEN-1)) begin
        r_clk_f  <= r_clk_s[1];
        r_clk_fc <= '0;
      end else begin
        r_clk_fc <= r_clk_fc + 1'b1;
      end
      if (r_dat_s[1] == r_dat_f) begin
        r_dat_fc <= '0;
      end else if (r_dat_fc == FW'(FILTER_LEN-1)) begin
        r_dat_f  <= r_dat_s[1];
        r_dat_fc <= '0;
      end else begin
        r_dat_fc <= r_dat_fc + 1'b1;
      end
    end
  end

  assign w_fall = r_clk_fd & ~r_clk_f;

  state_t        r_state, w_state_n;
  logic [2:0]    r_bit, w_bit_n;
  logic [7:0]    r_shift, w_shift_n;
  logic          r_par, w_par_n;
  logic [TW-1:0] r_tmo;
  logic          w_tmo, w_push, w_par_set, w_frm_set;
  logic          r_push;
  logic [7:0]    r_push_b;

  assign w_tmo = (r_state != S_IDLE) &&
                 (r_tmo == TW'(TIMEOUT_CYC-1));

  always_comb begin
    w_state_n = r_state;
    w_bit_n   = r_bit;
    w_shift_n = r_shift;
    w_par_n   = r_par;
    w_push    = 1'b0;
    w_par_set = 1'b0;
    w_frm_set = 1'b0;
    if (!en_i) begin
      w_state_n = S_IDLE;
      w_bit_n   = 3'd0;
    end else if (w_fall) begin
      unique case (r_state)
        S_IDLE: begin
          if (!r_dat_f) begin
            w_state_n = S_DATA;
            w_bit_n   = 3'd0;
          end
        end
        S_DATA: begin
          w_shift_n[r_bit] = r_dat_f;
          if (r_bit == 3'd7) w_state_n = S_PAR;
          else w_bit_n = r_bit + 3'd1;
        end
        S_PAR: begin
          w_par_n   = r_dat_f;
          w_state_n = S_STOP;
        end
        S_STOP: begin
          w_state_n = S_IDLE;
          if (!r_dat_f) w_frm_set = 1'b1;
          else if (^{r_shift, r_par}) w_push = 1'b1;
          else w_par_set = 1'b1;
        end
        default: w_state_n = S_IDLE;
      endcase
    end else if (w_tmo) begin
      w_state_n = S_IDLE;
      w_frm_set = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_bit    <= 3'd0;
      r_shift  <= 8'h00;
      r_par    <= 1'b0;
      r_tmo    <= '0;
      r_push   <= 1'b0;
      r_push_b <= 8'h00;
    end else begin
      r_state  <= w_state_n;
      r_bit    <= w_bit_n;
      r_shift  <= w_shift_n;
      r_par    <= w_par_n;
      r_push   <= w_push;
      r_push_b <= r_shift;
      if (!en_i || r_state == S_IDLE || w_fall)
        r_tmo <= '0;
      else if (!w_tmo)
        r_tmo <= r_tmo + 1'b1;
      else
        r_tmo <= '0;
    end
  end

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wp, r_rp;
  logic [CNT_W-1:0] r_count;
  logic             w_empty, w_full, w_rd, w_wr, w_ovf_set;
  logic             r_par_err, r_frm_err, r_ovf, r_irq;
  logic             w_lvl;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_rd      = rd_en_i & ~w_empty;
  // A full FIFO still accepts the byte when a pop
  // frees the head in the same cycle.
  assign w_wr      = r_push & (~w_full | w_rd);
  assign w_ovf_set = r_push & w_full & ~w_rd;

  always_ff @(posedge clk_i) begin
    if (w_wr) r_mem[r_wp] <= r_push_b;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_rd) r_rp <= r_rp + 1'b1;
      if (w_wr && !w_rd)
        r_count <= r_count + 1'b1;
      else if (w_rd && !w_wr)
        r_count <= r_count - 1'b1;
    end
  end

  assign w_lvl = (irq_thresh_i != '0) &&
                 (r_count >= irq_thresh_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_par_err <= 1'b0;
      r_frm_err <= 1'b0;
      r_ovf     <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_par_err <= w_par_set | (r_par_err & ~clr_err_i);
      r_frm_err <= w_frm_set | (r_frm_err & ~clr_err_i);
      r_ovf     <= w_ovf_set | (r_ovf & ~clr_err_i);
      r_irq     <= w_lvl | r_par_err | r_frm_err | r_ovf;
    end
  end

  assign dat_o     = w_empty ? 8'h00 : r_mem[r_rp];
  assign empty_o   = w_empty;
  assign full_o    = w_full;
  assign count_o   = r_count;
  assign par_err_o = r_par_err;
  assign frm_err_o = r_frm_err;
  assign ovf_o     = r_ovf;
  assign irq_o     = r_irq;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo.
// Scoreboard queue holds bytes expected out of the FIFO.
module tb_ps2_rx_fifo;

  localparam int DEPTH = 8;
  localparam int FLEN  = 4;
  localparam int TMO   = 5000;
  localparam int CW    = $clog2(DEPTH+1);
  localparam int HF    = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b1;
  logic          ps2_clk = 1'b1;
  logic          ps2_dat = 1'b1;
  logic          rd_en = 1'b0;
  logic [CW-1:0] thresh = '0;
  logic          clr_err = 1'b0;
  logic [7:0]    dat;
  logic          empty, full, par_err, frm_err, ovf, irq;
  logic [CW-1:0] count;

  int n_vec = 0;
  int n_bad = 0;
  logic [7:0] sb [$];
  logic [7:0] exp_b;

  ps2_rx_fifo #(
    .FIFO_DEPTH(DEPTH), .FILTER_LEN(FLEN),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en),
    .ps2_clk_i(ps2_clk), .ps2_dat_i(ps2_dat),
    .rd_en_i(rd_en), .irq_thresh_i(thresh),
    .clr_err_i(clr_err), .dat_o(dat),
    .empty_o(empty), .full_o(full),
    .count_o(count), .par_err_o(par_err),
    .frm_err_o(frm_err), .ovf_o(ovf), .irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ps2_bit(input logic b, input int h,
                         input bit gl);
    ps2_dat = b;
    if (gl) begin
      tick(h/4);
      ps2_clk = 1'b0;
      tick(1);
      ps2_clk = 1'b1;
      tick(h/2 - h/4 - 1);
    end else begin
      tick(h/2);
    end
    ps2_clk = 1'b0;
    tick(h);
    ps2_clk = 1'b1;
    tick(h/2);
  endtask

  task automatic send_frame(input logic [7:0] d,
                            input logic par,
                            input logic stop,
                            input int h, input int nb,
                            input bit gl);
    logic [10:0] b;
    b = {stop, par, d, 1'b0};
    for (int i = 0; i < nb; i++) ps2_bit(b[i], h, gl);
    ps2_dat = 1'b1;
    tick(10);
  endtask

  task automatic pulse_rd();
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(10);
    n_vec++;
    if (dat !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_dat got %h want 00", dat);
    end
    n_vec++;
    if ({empty, full, count} !== {1'b1, 1'b0, CW'(0)}) begin
      n_bad++;
      $display("FAIL reset_fifo got e%b f%b c%0d want e1 f0 c0",
               empty, full, count);
    end
    n_vec++;
    if ({par_err, frm_err, ovf, irq} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_flags got %b want 0000",
               {par_err, frm_err, ovf, irq});
    end
  endtask

  task automatic test_basic();
    thresh = CW'(1);
    sb.push_back(8'hA5);
    send_frame(8'hA5, ~^8'hA5, 1'b1, 100, 11, 1'b0);
    n_vec++;
    if (count !== CW'(1)) begin
      n_bad++;
      $display("FAIL basic_count got %0d want 1", count);
    end
    exp_b = sb.pop_front();
    n_vec++;
    if (dat !== exp_b) begin
      n_bad++;
      $display("FAIL basic_dat got %h want %h", dat, exp_b);
    end
    n_vec++;
    if ({par_err, frm_err, ovf, irq} !== 4'b0001) begin
      n_bad++;
      $display("FAIL basic_flags got %b want 0001",
               {par_err, frm_err, ovf, irq});
    end
    pulse_rd();
    n_vec++;
    if (empty !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_empty got %b want 1", empty);
    end
    tick(1);
    n_vec++;
    if (irq !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_irq_clr got %b want 0", irq);
    end
  endtask

  task automatic test_parity();
    send_frame(8'h3C, ^8'h3C, 1'b1, HF, 11, 1'b0);
    n_vec++;
    if ({par_err, frm_err, count} !== {2'b10, CW'(0)}) begin
      n_bad++;
      $display("FAIL par_err got p%b f%b c%0d want p1 f0 c0",
               par_err, frm_err, count);
    end
    n_vec++;
    if (irq !== 1'b1) begin
      n_bad++;
      $display("FAIL par_irq got %b want 1", irq);
    end
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    n_vec++;
    if (par_err !== 1'b0) begin
      n_bad++;
      $display("FAIL par_clr got %b want 0", par_err);
    end
    tick(1);
    n_vec++;
    if (irq !== 1'b0) begin
      n_bad++;
      $display("FAIL par_irq_clr got %b want 0", irq);
    end
  endtask

  task automatic test_framing();
    send_frame(8'h12, ~^8'h12, 1'b0, HF, 11, 1'b0);
    n_vec++;
    if ({frm_err, par_err, count} !== {2'b10, CW'(0)}) begin
      n_bad++;
      $display("FAIL frm_stop got f%b p%b c%0d want f1 p0 c0",
               frm_err, par_err, count);
    end
    pulse_clr();
    send_frame(8'hF0, 1'b0, 1'b1, HF, 5, 1'b0);
    tick(TMO - 200);
    n_vec++;
    if (frm_err !== 1'b0) begin
      n_bad++;
      $display("FAIL tmo_early got %b want 0", frm_err);
    end
    tick(300);
    n_vec++;
    if ({frm_err, count} !== {1'b1, CW'(0)}) begin
      n_bad++;
      $display("FAIL tmo_fire got f%b c%0d want f1 c0",
               frm_err, count);
    end
    pulse_clr();
    sb.push_back(8'h55);
    send_frame(8'h55, ~^8'h55, 1'b1, HF, 11, 1'b0);
    exp_b = sb.pop_front();
    n_vec++;
    if ({count, dat, frm_err} !== {CW'(1), exp_b, 1'b0}) begin
      n_bad++;
      $display("FAIL tmo_next got c%0d d%h f%b want c1 d%h f0",
               count, dat, frm_err, exp_b);
    end
    pulse_rd();
    tick(2);
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 3; i++) begin
      ps2_clk = 1'b0;
      tick(1);
      ps2_clk = 1'b1;
      tick(10);
    end
    sb.push_back(8'h81);
    send_frame(8'h81, ~^8'h81, 1'b1, HF, 11, 1'b1);
    exp_b = sb.pop_front();
    n_vec++;
    if ({count, dat} !== {CW'(1), exp_b}) begin
      n_bad++;
      $display("FAIL glitch_rx got c%0d d%h want c1 d%h",
               count, dat, exp_b);
    end
    n_vec++;
    if ({par_err, frm_err, ovf} !== 3'b000) begin
      n_bad++;
      $display("FAIL glitch_err got %b want 000",
               {par_err, frm_err, ovf});
    end
    pulse_rd();
    tick(2);
  endtask

  task automatic test_overflow();
    thresh = '0;
    for (int i = 0; i < 9; i++) begin
      if (i < DEPTH) sb.push_back(8'(i));
      send_frame(8'(i), ~^8'(i), 1'b1, HF, 11, 1'b0);
    end
    n_vec++;
    if ({full, ovf, count} !== {2'b11, CW'(DEPTH)}) begin
      n_bad++;
      $display("FAIL ovf_full got f%b o%b c%0d want f1 o1 c%0d",
               full, ovf, count, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) begin
      exp_b = sb.pop_front();
      n_vec++;
      if (dat !== exp_b) begin
        n_bad++;
        $display("FAIL ovf_read%0d got %h want %h",
                 i, dat, exp_b);
      end
      pulse_rd();
    end
    n_vec++;
    if (empty !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_empty got %b want 1", empty);
    end
    pulse_clr();
  endtask

  task automatic test_back_to_back();
    logic [10:0] b;
    for (int i = 0; i < DEPTH; i++) begin
      sb.push_back(8'h10 + 8'(i));
      send_frame(8'h10 + 8'(i), ~^(8'h10 + 8'(i)),
                 1'b1, HF, 11, 1'b0);
    end
    b = {1'b1, ~^8'h18, 8'h18, 1'b0};
    for (int i = 0; i < 10; i++) ps2_bit(b[i], HF, 1'b0);
    // Stop bit: line falls, then 2 sync + FLEN filter cycles,
    // a strobe cycle, and the write one cycle later.
    ps2_dat = 1'b1;
    tick(HF/2);
    ps2_clk = 1'b0;
    tick(2 + FLEN + 1);
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    void'(sb.pop_front());
    sb.push_back(8'h18);
    tick(HF - (2 + FLEN + 2));
    ps2_clk = 1'b1;
    tick(HF/2 + 10);
    n_vec++;
    if ({full, ovf, count} !== {2'b10, CW'(DEPTH)}) begin
      n_bad++;
      $display("FAIL b2b_full got f%b o%b c%0d want f1 o0 c%0d",
               full, ovf, count, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) begin
      exp_b = sb.pop_front();
      n_vec++;
      if (dat !== exp_b) begin
        n_bad++;
        $display("FAIL b2b_read%0d got %h want %h",
                 i, dat, exp_b);
      end
      pulse_rd();
    end
    pulse_rd();
    tick(1);
    n_vec++;
    if ({empty, count, ovf} !== {1'b1, CW'(0), 1'b0}) begin
      n_bad++;
      $display("FAIL rd_empty got e%b c%0d o%b want e1 c0 o0",
               empty, count, ovf);
    end
  endtask

  task automatic test_rst_mid();
    thresh = CW'(1);
    send_frame(8'h77, ~^8'h77, 1'b1, HF, 11, 1'b0);
    send_frame(8'hC3, 1'b0, 1'b1, HF, 4, 1'b0);
    rst = 1'b1;
    tick(1);
    n_vec++;
    if ({dat, empty, full, count} !==
        {8'h00, 1'b1, 1'b0, CW'(0)}) begin
      n_bad++;
      $display("FAIL rst_fifo got d%h e%b f%b c%0d want 00 1 0 0",
               dat, empty, full, count);
    end
    n_vec++;
    if ({par_err, frm_err, ovf, irq} !== 4'b0000) begin
      n_bad++;
      $display("FAIL rst_flags got %b want 0000",
               {par_err, frm_err, ovf, irq});
    end
    rst = 1'b0;
    tick(10);
    sb.push_back(8'h42);
    send_frame(8'h42, ~^8'h42, 1'b1, HF, 11, 1'b0);
    exp_b = sb.pop_front();
    n_vec++;
    if ({count, dat, frm_err, par_err} !==
        {CW'(1), exp_b, 2'b00}) begin
      n_bad++;
      $display("FAIL rst_next got c%0d d%h e%b want c1 d%h e00",
               count, dat, {frm_err, par_err}, exp_b);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_framing();
    test_glitch();
    test_overflow();
    test_back_to_back();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
